// File: rtl/gray_to_bin_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin_decoder_pkg
// Description : Shared constants and helpers for the Gray-code path
//               (default word width, Gray-to-binary conversion, popcount).
// Revision    : 1.0 - initial release
// ============================================================================
package gray_to_bin_decoder_pkg;

  // Default Gray/binary word width, shared with the encoder side.
  localparam int c_gray_width = 4;

  // Gray to binary on a zero-extended 32-bit word; zero upper Gray bits
  // decode to zero upper binary bits, so callers can truncate freely.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits in a 32-bit word (0..32).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin_decoder_gray_step_checker.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_checker
// Description : Combinational classification of a Gray step against the
//               previously accepted word: first / repeat / multi-bit error.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step_checker
  import gray_to_bin_decoder_pkg::*;
#(
  parameter int WIDTH = c_gray_width
) (
  input  logic [WIDTH-1:0] in_gray,
  input  logic [WIDTH-1:0] prev_gray,
  input  logic             have_prev,
  output logic             first,
  output logic             dup,
  output logic             err
);

  logic [5:0] w_dist;

  // Hamming distance to the previous word decides the class; with no
  // history the word is "first" and neither other flag may be set.
  always_comb begin
    w_dist = popcount(32'(in_gray ^ prev_gray));
    first  = !have_prev;
    dup    = have_prev && (w_dist == 6'd0);
    err    = have_prev && (w_dist > 6'd1);
  end

endmodule
`default_nettype wire

// File: rtl/gray_to_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin_decoder
// Description : Two-stage valid/ready Gray-to-binary decoder with a
//               single-bit-step monitor and saturating step-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_to_bin_decoder
  import gray_to_bin_decoder_pkg::*;
#(
  parameter int WIDTH = c_gray_width,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_first,
  output logic             out_repeat,
  output logic             out_step_err,
  output logic [CNT_W-1:0] err_count
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_gray;
  logic             r_s1_first;
  logic             r_s1_dup;
  logic             r_s1_err;
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;

  logic w_s2_can_load;
  logic w_s1_move;
  logic w_accept;
  logic w_chk_have_prev;
  logic w_first;
  logic w_dup;
  logic w_err;

  // S2 frees up when empty or handing its word downstream this cycle;
  // in_ready therefore chains combinationally from out_ready.
  assign w_s2_can_load   = !out_valid || out_ready;
  assign w_s1_move       = r_s1_valid && w_s2_can_load;
  assign in_ready        = !r_s1_valid || w_s2_can_load;
  assign w_accept        = in_valid && in_ready;
  // A clr coincident with an accept makes that word the first of a new run.
  assign w_chk_have_prev = r_have_prev && !clr;

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_step_checker (
    .in_gray   (in_gray),
    .prev_gray (r_prev_gray),
    .have_prev (w_chk_have_prev),
    .first     (w_first),
    .dup       (w_dup),
    .err       (w_err)
  );

  // Stage S1: capture the Gray word with its step classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_gray  <= '0;
      r_s1_first <= 1'b0;
      r_s1_dup   <= 1'b0;
      r_s1_err   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_gray  <= in_gray;
      r_s1_first <= w_first;
      r_s1_dup   <= w_dup;
      r_s1_err   <= w_err;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage S2: decode to binary; contents hold while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_bin      <= '0;
      out_first    <= 1'b0;
      out_repeat   <= 1'b0;
      out_step_err <= 1'b0;
    end else if (w_s2_can_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_bin      <= WIDTH'(gray2bin(32'(r_s1_gray)));
        out_first    <= r_s1_first;
        out_repeat   <= r_s1_dup;
        out_step_err <= r_s1_err;
      end
    end
  end

  // Sequence history: every accept becomes the new reference word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
    end else if (w_accept) begin
      r_prev_gray <= in_gray;
      r_have_prev <= 1'b1;
    end else if (clr) begin
      r_have_prev <= 1'b0;
    end
  end

  // Saturating error counter, bumped at input accept (not output transfer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (w_accept && w_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_to_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_to_bin_decoder
// Description : Self-checking bench for gray_to_bin_decoder (WIDTH=4,
//               CNT_W=2) with an expected-result queue and directed steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_to_bin_decoder;

  localparam int W     = 4;
  localparam int CW    = 2;
  localparam int C_SAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_gray = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_bin;
  logic          out_first;
  logic          out_repeat;
  logic          out_step_err;
  logic [CW-1:0] err_count;

  gray_to_bin_decoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_gray      (in_gray),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bin      (out_bin),
    .out_first    (out_first),
    .out_repeat   (out_repeat),
    .out_step_err (out_step_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic         f;
    logic         r;
    logic         e;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_acc = 0;
  bit           exact_lat = 1'b0;
  logic         m_have = 1'b0;
  logic [W-1:0] m_prev = '0;
  int           m_cnt = 0;
  exp_t         me;
  exp_t         pe;
  int           md;
  logic         mhv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] g2b_ref(input logic [W-1:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  // Scoreboard: push expectations on accept, pop and compare on transfer.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_have = 1'b0;
      m_prev = '0;
      m_cnt  = 0;
    end else begin
      chk("err_count_track", 32'(err_count), 32'(m_cnt));
      if (in_valid && in_ready) begin
        mhv    = m_have && !clr;
        md     = $countones(in_gray ^ m_prev);
        me.bin = g2b_ref(in_gray);
        me.f   = !mhv;
        me.r   = mhv && (md == 0);
        me.e   = mhv && (md > 1);
        me.cyc = cyc;
        q.push_back(me);
        n_acc++;
        m_prev = in_gray;
        m_have = 1'b1;
        if (me.e && m_cnt < C_SAT) m_cnt++;
      end else if (clr) begin
        m_have = 1'b0;
      end
      if (clr) m_cnt = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_out observed=%0h expected=none", out_bin);
        end else begin
          pe = q.pop_front();
          chk("out_word", 32'({out_bin, out_first, out_repeat, out_step_err}),
              32'({pe.bin, pe.f, pe.r, pe.e}));
          if (exact_lat) chk("latency", 32'(cyc - pe.cyc), 32'd2);
          else           chk("latency_min", 32'(cyc - pe.cyc >= 2), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] g);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_gray  = g;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=in_ready0 expected=in_ready1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((q.size() != 0 || out_valid) && n < 50);
    if (q.size() != 0 || out_valid) begin
      total++;
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] arr [5];
    int           idx;
    int           a0;
    bit           ok;
    arr[0] = 4'b0000; arr[1] = 4'b0001; arr[2] = 4'b0011;
    arr[3] = 4'b0010; arr[4] = 4'b0110;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_flags", 32'({out_first, out_repeat, out_step_err}), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exact_lat = 1'b1;

    // Short stream 0,1,2,3
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010);
    in_valid = 1'b0;
    drain();
    chk("t1_err_count", 32'(err_count), 32'd0);

    // Full Gray cycle with wrap 1000 -> 0000
    clr_pulse();
    for (int b = 0; b < 16; b++) send(W'(b ^ (b >> 1)));
    send(4'b0000);
    in_valid = 1'b0;
    drain();
    chk("t2_err_count", 32'(err_count), 32'd0);

    // first / err / repeat / err
    clr_pulse();
    send(4'b0000); send(4'b0011); send(4'b0011); send(4'b0110);
    in_valid = 1'b0;
    drain();
    chk("t3_err_count", 32'(err_count), 32'd2);

    // Backpressure: only two words fit while out_ready is low
    clr_pulse();
    exact_lat = 1'b0;
    out_ready = 1'b0;
    a0 = n_acc;
    idx = 0;
    in_valid = 1'b1;
    repeat (6) begin
      in_gray = arr[idx];
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    chk("stall_accepts", 32'(n_acc - a0), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_out_bin", 32'(out_bin), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_hold_bin", 32'(out_bin), 32'd0);
    chk("stall_hold_first", 32'(out_first), 32'd1);
    out_ready = 1'b1;
    while (idx < 5) begin
      send(arr[idx]);
      idx++;
    end
    in_valid = 1'b0;
    drain();

    // Saturation then clr coincident with an accept
    clr_pulse();
    exact_lat = 1'b1;
    send(4'b0000); send(4'b0011); send(4'b0000);
    send(4'b0011); send(4'b0000); send(4'b0011);
    in_valid = 1'b0;
    drain();
    chk("sat_err_count", 32'(err_count), 32'd3);
    clr = 1'b1;
    send(4'b0110);
    clr = 1'b0;
    send(4'b0111);
    in_valid = 1'b0;
    drain();
    chk("clr_acc_err_count", 32'(err_count), 32'd0);

    // Asynchronous reset with two words in flight
    exact_lat = 1'b0;
    out_ready = 1'b0;
    send(4'b0000); send(4'b0011);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_err_count", 32'(err_count), 32'd2);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(4'b0101);
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_to_bin_decoder.md
Name: gray_to_bin_decoder

Overview:
- Receive side of the team's Gray-code path: accepts WIDTH-bit Gray words over a valid/ready stream and returns the binary equivalent.
- Two-stage pipeline with full backpressure.
- Monitors the incoming Gray sequence and flags any step that is not a single-bit transition, as expected from a Gray counter.
- Used wherever the encoder's output is sampled back into binary, for example a counter crossing a domain or a position encoder.

Parameters:
- WIDTH, 4, Gray/binary word width (>= 2).
- CNT_W, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of sequence history and error counter.
- in_valid  input  1  in_gray is valid.
- in_ready  output  1  decoder can accept a word this cycle.
- in_gray  input  WIDTH  Gray-coded word.
- out_valid  output  1  out_bin and flags are valid.
- out_ready  input  1  downstream accepts the output.
- out_bin  output  WIDTH  decoded binary word.
- out_first  output  1  word was the first after reset or clr (no step check done).
- out_repeat  output  1  word is identical to the previous accepted word.
- out_step_err  output  1  previous-to-current Hamming distance > 1.
- err_count  output  CNT_W  saturating count of step errors.

Behaviour:
- Reset: clk and rst_n as named above. One clock; reset is asynchronous and active-low. While rst_n = 0:
  - all valids, out_bin, flags and err_count are 0;
  - the internal have_prev flag is 0 and prev_gray is 0.
- Accept and transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - Stage S1 registers the Gray word and the step classification. Stage S2 registers the binary word and the flags.
  - S2 loads when S2 is empty or is transferring in the same cycle.
  - S1 loads when S1 is empty or is moving to S2 in the same cycle.
  - in_ready = !s1_valid || s2_can_load. This is a combinational chain from out_ready; it is legal within this block.
- Latency: minimum 2 cycles from input accept to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Data is held stable while out_valid && !out_ready. A bubble never drops data.
- Conversion, in stage S2:
  - b[WIDTH-1] = g[WIDTH-1];
  - b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Step check, computed at accept against prev_gray:
  - d = popcount(in_gray ^ prev_gray).
  - have_prev = 0 gives first = 1, repeat = 0, err = 0.
  - Otherwise repeat = (d == 0) and err = (d > 1).
  - At most one of first, repeat, err is set for any word.
  - On every accept, prev_gray takes in_gray and have_prev is set to 1.
- err_count:
  - Increments when a word with err = 1 is accepted at the input, not at output transfer.
  - Saturates at all-ones and never wraps.
- clr, synchronous:
  - clears have_prev and err_count;
  - pipeline contents and valids are untouched.
- clr in the same cycle as an accept: the accepted word is treated as first (first = 1, no count), and have_prev ends at 1.
- Wrap-around: a step from Gray 1000 to 0000 (binary 15 to 0 at WIDTH = 4) is a single-bit step and is not an error.
- Reset mid-stream: all in-flight words are discarded. The next accepted word is first.

Decomposition:
- Shared package holds:
  - a gray2bin function, used here and by benches;
  - a popcount function;
  - the default WIDTH constant shared with the encoder.
- Natural sub-module: gray_step_checker. It is combinational, takes in_gray, prev_gray and have_prev, and outputs first, repeat and err.
- The pipeline and counter stay in the top module.

Test Plan:
- Reset then stream Gray 0000, 0001, 0011, 0010 with out_ready = 1 → binary 0, 1, 2, 3 on consecutive cycles, starting 2 cycles after the first accept. out_first = 1 only on word 0. err_count = 0.
- Full 16-word Gray cycle plus wrap 1000 → 0000 → 16 outputs, then binary 0000. No step errors.
- Sequence 0000, 0011 (d = 2), 0011 (repeat), 0110 (d = 2) → flags: first; err; repeat; err. err_count = 2.
- Hold out_ready = 0 with continuous in_valid → exactly 2 words accepted, then in_ready = 0 and out_bin stays stable. Release out_ready → order preserved, nothing lost or duplicated.
- Force err_count to saturation (CNT_W = 2, 5 bad steps) → err_count reads 3. Then clr coincident with an accept → that word has first = 1 and err_count = 0.
- Assert rst_n low with 2 words in flight → out_valid = 0 and err_count = 0 immediately, without waiting for a clock edge. Next word after release is first.
